uart_rx_param: RTL and testbench

//  Parametrised UART receiver for the UART-ALU datapath: width, parity, stop bits and oversampling are configurable.

---
 rtl/uart_rx_param_pkg.sv | 29 ++
 rtl/uart_rx_param_if.sv | 27 ++
 rtl/uart_rx_param_baud_gen.sv | 40 ++++
 rtl/uart_rx_param.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver:
// parity mode constants, receiver FSM states and counter sizing helpers.
package uart_rx_param_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // Bits needed to hold values 0..n-1 (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Consumer-side bus of the UART receiver.
//   o_data / o_valid / i_ready : one-entry valid/ready word handshake
//   o_parity_err, o_frame_err, o_break, o_overrun : status of the held word
//   o_busy : receiver is inside a frame
// master = receiver, slave = consumer.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_overrun;
  logic                 o_busy;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun, o_busy,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun, o_busy,
    output i_ready
  );
endinterface

// File: rtl/uart_rx_param_baud_gen.sv
// Oversampling tick generator for the UART receiver.
//   i_clk     : system clock
//   i_reset   : synchronous, active-low reset
//   i_restart : realign the divider (start-bit edge)
//   o_tick    : one-cycle pulse every DIV clocks
module uart_baud_gen
  import uart_rx_param_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 19200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CW  = cnt_width(DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (i_restart) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt    <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
//   i_clk   : system clock, rising edge
//   i_reset : synchronous, active-low reset
//   i_rx    : asynchronous serial line, idle high
//   rx_bus  : word handshake and status flags (see uart_rx_param_if)
// The line is synchronised, a falling edge starts a frame and realigns the
// tick divider, and every bit is sampled at its mid-point. Completed frames
// land in a one-entry holding register; a frame completing while the
// register is full and not being accepted is dropped and flags overrun.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 19200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = PARITY_NONE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx,
  uart_rx_param_if.master   rx_bus
);

  localparam int unsigned TW = cnt_width(OVERSAMPLE);
  localparam int unsigned BW = cnt_width(10);

  rx_state_e state, state_n;

  logic [1:0]           sync_r;
  logic                 rx_s, rx_prev, fall;
  logic                 tick, restart, mid_start, bit_done, last_stop;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r, stop0_r, frame_err_r, commit_r;

  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r, perr_r, ferr_r, brk_r, ovr_r;
  logic                 accept, par_err_w, break_w;

  assign rx_s      = sync_r[1];
  assign fall      = rx_prev & ~rx_s;
  assign restart   = (state == S_IDLE) && fall;
  assign mid_start = tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
  assign bit_done  = tick && (tick_cnt == TW'(OVERSAMPLE - 1));

  uart_baud_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (restart),
    .o_tick    (tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    last_stop = 1'b0;
    case (state)
      S_IDLE:   if (fall) state_n = S_START;
      S_START:  if (mid_start) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (bit_done && bit_cnt == BW'(DATA_BITS - 1))
                  state_n = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_n = S_STOP;
      S_STOP:   if (bit_done && bit_cnt == BW'(STOP_BITS - 1)) begin
                  state_n   = S_IDLE;
                  last_stop = 1'b1;
                end
      default:  state_n = S_IDLE;
    endcase
  end

  // Counters restart on every state change, so each state counts its own
  // ticks and bits from zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync_r      <= 2'b11;
      rx_prev     <= 1'b1;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_r     <= '0;
      par_bit_r   <= 1'b0;
      stop0_r     <= 1'b0;
      frame_err_r <= 1'b0;
      commit_r    <= 1'b0;
    end else begin
      sync_r   <= {sync_r[0], i_rx};
      rx_prev  <= rx_s;
      commit_r <= last_stop;

      if (state_n != state || state == S_IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (tick) begin
        if (state == S_START) begin
          tick_cnt <= tick_cnt + 1'b1;
        end else if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
          tick_cnt <= '0;
          bit_cnt  <= bit_cnt + 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end

      if (restart) frame_err_r <= 1'b0;

      if (bit_done) begin
        case (state)
          S_DATA:   shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
          S_PARITY: par_bit_r <= rx_s;
          S_STOP: begin
            if (!rx_s) frame_err_r <= 1'b1;
            if (bit_cnt == '0) stop0_r <= rx_s;
          end
          default: ;
        endcase
      end
    end
  end

  assign par_err_w = (PARITY != PARITY_NONE) &&
                     ((^shift_r ^ par_bit_r) != (PARITY == PARITY_ODD));
  assign break_w   = (shift_r == '0) &&
                     ((PARITY == PARITY_NONE) || !par_bit_r) && !stop0_r;
  assign accept    = valid_r & rx_bus.i_ready;

  // Commit is one clock after the last stop sample; an accept on that same
  // edge frees the slot, so the new word loads instead of overrunning.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      brk_r   <= 1'b0;
      ovr_r   <= 1'b0;
    end else if (commit_r && (!valid_r || accept)) begin
      data_r  <= shift_r;
      valid_r <= 1'b1;
      perr_r  <= par_err_w;
      ferr_r  <= frame_err_r;
      brk_r   <= break_w;
      ovr_r   <= 1'b0;
    end else if (accept) begin
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      brk_r   <= 1'b0;
      ovr_r   <= 1'b0;
    end else if (commit_r) begin
      ovr_r   <= 1'b1;
    end
  end

  assign rx_bus.o_data       = data_r;
  assign rx_bus.o_valid      = valid_r;
  assign rx_bus.o_parity_err = perr_r;
  assign rx_bus.o_frame_err  = ferr_r;
  assign rx_bus.o_break      = brk_r;
  assign rx_bus.o_overrun    = ovr_r;
  assign rx_bus.o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receiver configurations driven with
// directed and random frames, checked against a frame-level model.
module tb_uart_rx_param;
  import uart_rx_param_pkg::*;

  localparam int unsigned CF = 1_000_000;

  logic       clk;
  logic       rst_n;
  logic [2:0] rx;
  logic [2:0] rdy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(7)) if2 ();

  assign if0.i_ready = rdy[0];
  assign if1.i_ready = rdy[1];
  assign if2.i_ready = rdy[2];

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(20000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1))
    dut0 (.i_clk(clk), .i_reset(rst_n), .i_rx(rx[0]), .rx_bus(if0));
  uart_rx_param #(.CLK_FREQ(CF), .BAUD(20000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1))
    dut1 (.i_clk(clk), .i_reset(rst_n), .i_rx(rx[1]), .rx_bus(if1));
  uart_rx_param #(.CLK_FREQ(CF), .BAUD(25000), .OVERSAMPLE(8), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2))
    dut2 (.i_clk(clk), .i_reset(rst_n), .i_rx(rx[2]), .rx_bus(if2));

  logic [8:0] o_data_a [3];
  logic [2:0] o_valid_a, o_perr_a, o_ferr_a, o_brk_a, o_ovr_a, o_busy_a;

  assign o_data_a[0] = 9'(if0.o_data);
  assign o_data_a[1] = 9'(if1.o_data);
  assign o_data_a[2] = 9'(if2.o_data);
  assign o_valid_a = {if2.o_valid, if1.o_valid, if0.o_valid};
  assign o_perr_a  = {if2.o_parity_err, if1.o_parity_err, if0.o_parity_err};
  assign o_ferr_a  = {if2.o_frame_err, if1.o_frame_err, if0.o_frame_err};
  assign o_brk_a   = {if2.o_break, if1.o_break, if0.o_break};
  assign o_ovr_a   = {if2.o_overrun, if1.o_overrun, if0.o_overrun};
  assign o_busy_a  = {if2.o_busy, if1.o_busy, if0.o_busy};

  // Configuration table of the three instances
  function automatic int unsigned cfg_bits(input int unsigned d);
    return (d == 2) ? 7 : 8;
  endfunction
  function automatic int unsigned cfg_par(input int unsigned d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 1;
  endfunction
  function automatic int unsigned cfg_stop(input int unsigned d);
    return (d == 2) ? 2 : 1;
  endfunction
  function automatic int unsigned bitclk(input int unsigned d);
    int unsigned baud, os;
    baud = (d == 2) ? 25000 : 20000;
    os   = (d == 2) ? 8 : 16;
    return ((CF + baud * os / 2) / (baud * os)) * os;
  endfunction

  // Parity bit that makes the frame correct for instance d
  function automatic logic good_pbit(input int unsigned d, input int unsigned data);
    int unsigned ones;
    ones = $countones(data);
    return (cfg_par(d) == 2) ? logic'(ones % 2) : logic'((ones + 1) % 2);
  endfunction

  // Frame-level expectation: {parity_err, frame_err, break}
  function automatic logic [2:0] exp_flags(input int unsigned d, input int unsigned data,
                                           input logic pbit, input logic [1:0] stops);
    int unsigned ones, want;
    logic perr, ferr, brk;
    ones = $countones(data);
    want = (cfg_par(d) == 1) ? 1 : 0;
    perr = (cfg_par(d) != 0) && (((ones + int'(pbit)) % 2) != want);
    ferr = !stops[0] || (cfg_stop(d) == 2 && !stops[1]);
    brk  = (data == 0) && (cfg_par(d) == 0 || !pbit) && !stops[0];
    return {perr, ferr, brk};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int unsigned d, input int unsigned data, input logic pbit,
                            input logic [1:0] stops, input int unsigned gap_bits);
    int unsigned bc;
    logic [8:0] dv;
    bc = bitclk(d);
    dv = 9'(data);
    rx[d] = 1'b0;
    wait_clk(bc);
    for (int unsigned i = 0; i < cfg_bits(d); i++) begin
      rx[d] = dv[i];
      wait_clk(bc);
    end
    if (cfg_par(d) != 0) begin
      rx[d] = pbit;
      wait_clk(bc);
    end
    for (int unsigned i = 0; i < cfg_stop(d); i++) begin
      rx[d] = stops[i];
      wait_clk(bc);
    end
    rx[d] = 1'b1;
    wait_clk(gap_bits * bc);
  endtask

  // Wait (bounded) for the held word, check it, then accept it.
  task automatic expect_word(input string tag, input int unsigned d, input int unsigned data,
                             input logic [2:0] flags, input logic ovr);
    int unsigned lim;
    lim = 0;
    while (!o_valid_a[d] && lim < 4 * bitclk(d)) begin
      @(negedge clk);
      lim++;
    end
    check({tag, ".valid"}, 32'(o_valid_a[d]), 32'd1);
    check({tag, ".data"},  32'(o_data_a[d]),  32'(data));
    check({tag, ".flags"}, 32'({o_perr_a[d], o_ferr_a[d], o_brk_a[d]}), 32'(flags));
    check({tag, ".ovr"},   32'(o_ovr_a[d]),   32'(ovr));
    check({tag, ".busy"},  32'(o_busy_a[d]),  32'd0);
    rdy[d] = 1'b1;
    @(negedge clk);
    rdy[d] = 1'b0;
    check({tag, ".acc_valid"}, 32'(o_valid_a[d]), 32'd0);
    check({tag, ".acc_ovr"},   32'(o_ovr_a[d]),   32'd0);
  endtask

  // Observe instance d for n cycles; return whether busy or valid were seen.
  task automatic watch(input int unsigned d, input int unsigned n,
                       output logic busy_seen, output logic valid_seen);
    busy_seen  = 1'b0;
    valid_seen = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      busy_seen  = busy_seen  | o_busy_a[d];
      valid_seen = valid_seen | o_valid_a[d];
    end
  endtask

  initial begin
    logic       bs, vs, pb;
    logic [1:0] st;
    int unsigned d, data, mask;

    rst_n = 1'b0;
    rx    = 3'b111;
    rdy   = 3'b000;
    wait_clk(5);
    for (int unsigned i = 0; i < 3; i++) begin
      check($sformatf("rst%0d.outs", i),
            32'({o_data_a[i], o_valid_a[i], o_perr_a[i], o_ferr_a[i], o_brk_a[i],
                 o_ovr_a[i], o_busy_a[i]}), 32'd0);
    end
    rst_n = 1'b1;
    wait_clk(5);

    // 8N1 basic word
    send_frame(0, 32'h20, 1'b0, 2'b11, 2);
    expect_word("t1", 0, 32'h20, 3'b000, 1'b0);

    // even parity: wrong then right parity bit
    send_frame(1, 32'h02, 1'b0, 2'b11, 2);
    expect_word("t2a", 1, 32'h02, 3'b100, 1'b0);
    send_frame(1, 32'h02, 1'b1, 2'b11, 2);
    expect_word("t2b", 1, 32'h02, 3'b000, 1'b0);

    // framing error and break
    send_frame(0, 32'h22, 1'b0, 2'b10, 2);
    expect_word("t3a", 0, 32'h22, 3'b010, 1'b0);
    send_frame(0, 32'h00, 1'b0, 2'b10, 2);
    expect_word("t3b", 0, 32'h00, 3'b011, 1'b0);

    // start-bit glitch shorter than half a bit
    rx[0] = 1'b0;
    wait_clk(bitclk(0) / 4);
    rx[0] = 1'b1;
    watch(0, 3 * bitclk(0), bs, vs);
    check("t4.busy_pulse", 32'(bs), 32'd1);
    check("t4.no_valid",   32'(vs), 32'd0);
    check("t4.idle",       32'(o_busy_a[0]), 32'd0);
    send_frame(0, 32'h25, 1'b0, 2'b11, 2);
    expect_word("t4b", 0, 32'h25, 3'b000, 1'b0);

    // overrun: two back-to-back frames with nobody accepting
    send_frame(0, 32'h20, 1'b0, 2'b11, 0);
    send_frame(0, 32'h25, 1'b0, 2'b11, 2);
    expect_word("t5", 0, 32'h20, 3'b000, 1'b1);

    // 7O2 word, then reset in the middle of the next frame
    send_frame(2, 32'h55, good_pbit(2, 32'h55), 2'b11, 2);
    expect_word("t6a", 2, 32'h55, 3'b000, 1'b0);
    rx[2] = 1'b0;
    wait_clk(3 * bitclk(2));
    rst_n = 1'b0;
    wait_clk(3);
    check("t6.rst_outs",
          32'({o_data_a[2], o_valid_a[2], o_perr_a[2], o_ferr_a[2], o_brk_a[2],
               o_ovr_a[2], o_busy_a[2]}), 32'd0);
    rx[2] = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    watch(2, 14 * bitclk(2), bs, vs);
    check("t6.no_valid", 32'(vs), 32'd0);
    check("t6.no_busy",  32'(bs), 32'd0);

    // random frames on random instances
    for (int unsigned k = 0; k < 36; k++) begin
      d    = $urandom_range(0, 2);
      mask = (1 << cfg_bits(d)) - 1;
      data = $urandom & mask;
      if ($urandom_range(0, 5) == 0) data = 0;
      pb   = good_pbit(d, data);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      st[0] = ($urandom_range(0, 7) != 0);
      st[1] = ($urandom_range(0, 7) != 0);
      if (cfg_stop(d) == 1) st[1] = 1'b1;
      send_frame(d, data, pb, st, 1 + $urandom_range(0, 1));
      expect_word($sformatf("rnd%0d", k), d, data, exp_flags(d, data, pb, st), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
